// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared constants for the iterative multiply/divide unit
package mdu_pkg;

   localparam int XLEN_DEFAULT  = 32;
   localparam int CNT_W_DEFAULT = 5;

   typedef logic [1:0] op_t;

   localparam op_t OP_MUL   = 2'b00;
   localparam op_t OP_MULHU = 2'b01;
   localparam op_t OP_DIVU  = 2'b10;
   localparam op_t OP_REMU  = 2'b11;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

endpackage

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one shift-add multiply or restoring divide iteration
module mdu_step
   import mdu_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [1:0]      op_i,
   input  logic [XLEN:0]   acc_i,
   input  logic [XLEN-1:0] lo_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN:0]   acc_o,
   output logic [XLEN-1:0] lo_o
);

   logic [XLEN:0]   sum;
   logic [XLEN+1:0] acc_sh;
   logic [XLEN+1:0] diff;

   always_comb begin
      sum    = {1'b0, acc_i[XLEN-1:0]} + (lo_i[0] ? {1'b0, b_i} : '0);
      acc_sh = {acc_i, lo_i[XLEN-1]};
      diff   = acc_sh - {2'b00, b_i};
      acc_o  = '0;
      lo_o   = '0;
      if (op_i == OP_MUL || op_i == OP_MULHU) begin
         // carry of the add lands in hi[XLEN-1] after the right shift
         acc_o = {1'b0, sum[XLEN:1]};
         lo_o  = {sum[0], lo_i[XLEN-1:1]};
      end else if (!diff[XLEN+1]) begin
         acc_o = diff[XLEN:0];
         lo_o  = {lo_i[XLEN-2:0], 1'b1};
      end else begin
         acc_o = acc_sh[XLEN:0];
         lo_o  = {lo_i[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - iterative MUL/MULHU/DIVU/REMU unit; MDU_EARLY_OUT_EN enables trivial-operand early exit
module mdu_iterative
   import mdu_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            wr_en,
   output logic [4:0]      wr_addr
);

   logic [1:0]      state_q, state_d;
   logic [1:0]      op_q, op_d;
   logic [XLEN:0]   acc_q, acc_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [4:0]      rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            done_q, done_d;
   logic [XLEN-1:0] result_q, result_d;

   logic [XLEN:0]   step_acc;
   logic [XLEN-1:0] step_lo;

   mdu_step #(.XLEN(XLEN)) u_step (
      .op_i  (op_q),
      .acc_i (acc_q),
      .lo_i  (lo_q),
      .b_i   (b_q),
      .acc_o (step_acc),
      .lo_o  (step_lo)
   );

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      acc_d    = acc_q;
      lo_d     = lo_q;
      b_d      = b_q;
      rd_d     = rd_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d  = op;
               b_d   = b;
               rd_d  = rd_in;
               cnt_d = '0;
               acc_d = '0;
               lo_d  = a;
               state_d = S_CALC;
               // early exits preload acc/lo so FIN's normal result mux yields the answer
               if (op == OP_DIVU || op == OP_REMU) begin
                  if (b == '0) begin
                     acc_d   = {1'b0, a};
                     lo_d    = '1;
                     state_d = S_FIN;
                  end
`ifdef MDU_EARLY_OUT_EN
                  else if (a < b) begin
                     acc_d   = {1'b0, a};
                     lo_d    = '0;
                     state_d = S_FIN;
                  end
`endif
               end
`ifdef MDU_EARLY_OUT_EN
               else if (a == '0 || b == '0) begin
                  lo_d    = '0;
                  state_d = S_FIN;
               end
`endif
            end
         end
         S_CALC: begin
            acc_d = step_acc;
            lo_d  = step_lo;
            if (cnt_q == CNT_W'(XLEN - 1)) begin
               state_d = S_FIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_FIN: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            case (op_q)
               OP_MULHU, OP_REMU: result_d = acc_q[XLEN-1:0];
               default:           result_d = lo_q;
            endcase
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         acc_q    <= '0;
         lo_q     <= '0;
         b_q      <= '0;
         rd_q     <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         lo_q     <= lo_d;
         b_q      <= b_d;
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign busy    = (state_q != S_IDLE);
   assign done    = done_q;
   assign wr_en   = done_q;
   assign result  = result_q;
   assign wr_addr = rd_q;

endmodule
